// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path.
// Contents: FSM state encodings (4 bits), opcode and funct constants,
// ALU operand mux encodings, pc_src encodings, alu_op codes, and a helper
// that maps an R-type funct field to its ALU operation.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET_ST  = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    WB_R      = 4'd4,
    EXEC_I    = 4'd5,
    WB_I      = 4'd6,
    MEM_ADDR  = 4'd7,
    MEM_RD    = 4'd8,
    MEM_WR    = 4'd9,
    WB_LW     = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    EXCEPTION = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // ALU operand A mux
  localparam logic       MUXA_PC   = 1'b0;
  localparam logic       MUXA_REGA = 1'b1;

  // ALU operand B mux
  localparam logic [1:0] MUXB_REGB    = 2'b00;
  localparam logic [1:0] MUXB_FOUR    = 2'b01;
  localparam logic [1:0] MUXB_IMM     = 2'b10;
  localparam logic [1:0] MUXB_IMM_SL2 = 2'b11;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // ALU operations
  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;

  // Unrecognised funct codes fall back to add.
  function automatic logic [2:0] funct_to_alu_op(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// 3-bit wait-state counter for memory-access states.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-low reset (clears the count)
//   i_clr   in  clear count to 0 (priority over enable)
//   i_en    in  count up; holds once the count reaches MEM_WAIT_CYCLES
//   o_done  out count == MEM_WAIT_CYCLES
module wait_counter #(
  parameter int unsigned MEM_WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam logic [2:0] W_LIMIT = 3'(MEM_WAIT_CYCLES);

  logic [2:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_done) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_done = (r_cnt == W_LIMIT);

endmodule

// File: rtl/alu_src_control_fsm.sv
// Multicycle Moore control FSM: sequences fetch, decode, execute, memory
// and writeback; drives the ALU operand muxes and datapath write strobes.
// Optional feature macro: OPCODE_EXCEPTION_EN (unknown opcode -> EXCEPTION
// state; otherwise unknown opcodes are NOPs and exc_flag stays 0).
// Ports:
//   clk, reset (sync, active-low)  opcode[5:0], funct[5:0]  alu_zero
//   mux_a_control, mux_b_control[1:0], alu_op[2:0], pc_src[1:0]
//   pc_write, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg
//   exc_flag, state_out[3:0] (debug)
// While reset is low every output is forced to 0.
module alu_src_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic       mux_a_control,
  output logic [1:0] mux_b_control,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exc_flag,
  output logic [3:0] state_out
);

  state_t r_state;
  logic   w_in_wait;
  logic   w_done;
  logic   w_cnt_clr;

  // The state only changes outside wait states or when the wait is done,
  // so clearing on those conditions zeroes the count on every state entry.
  assign w_in_wait = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
  assign w_cnt_clr = !w_in_wait || w_done;

  wait_counter #(
    .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_en   (w_in_wait),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RESET_ST;
    end else begin
      case (r_state)
        RESET_ST: r_state <= FETCH;
        FETCH:    if (w_done) r_state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:      r_state <= EXEC_R;
            OP_ADDI:       r_state <= EXEC_I;
            OP_LW, OP_SW:  r_state <= MEM_ADDR;
            OP_BEQ, OP_BNE: r_state <= BRANCH;
            OP_J:          r_state <= JUMP;
`ifdef OPCODE_EXCEPTION_EN
            default:       r_state <= EXCEPTION;
`else
            default:       r_state <= FETCH;
`endif
          endcase
        end
        EXEC_R:   r_state <= WB_R;
        WB_R:     r_state <= FETCH;
        EXEC_I:   r_state <= WB_I;
        WB_I:     r_state <= FETCH;
        MEM_ADDR: r_state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (w_done) r_state <= WB_LW;
        MEM_WR:   if (w_done) r_state <= FETCH;
        WB_LW:    r_state <= FETCH;
        BRANCH:   r_state <= FETCH;
        JUMP:     r_state <= FETCH;
        EXCEPTION: r_state <= FETCH;
        default:  r_state <= RESET_ST;
      endcase
    end
  end

  always_comb begin
    mux_a_control = MUXA_PC;
    mux_b_control = MUXB_REGB;
    alu_op        = ALU_PASS_A;
    pc_src        = PCSRC_ALU;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    exc_flag      = 1'b0;
    state_out     = '0;
    if (reset) begin
      state_out = r_state;
      case (r_state)
        FETCH: begin
          mux_b_control = MUXB_FOUR;
          alu_op        = ALU_ADD;
          ir_write      = w_done;
          pc_write      = w_done;
        end
        DECODE: begin
          mux_b_control = MUXB_IMM_SL2;
          alu_op        = ALU_ADD;
        end
        EXEC_R: begin
          mux_a_control = MUXA_REGA;
          alu_op        = funct_to_alu_op(funct);
        end
        WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        EXEC_I, MEM_ADDR: begin
          mux_a_control = MUXA_REGA;
          mux_b_control = MUXB_IMM;
          alu_op        = ALU_ADD;
        end
        WB_I: reg_write = 1'b1;
        MEM_RD: iord = 1'b1;
        MEM_WR: begin
          iord      = 1'b1;
          mem_write = w_done;
        end
        WB_LW: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        BRANCH: begin
          mux_a_control = MUXA_REGA;
          alu_op        = ALU_SUB;
          pc_src        = PCSRC_ALUOUT;
          pc_write      = (opcode == OP_BNE) ? !alu_zero : alu_zero;
        end
        JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
`ifdef OPCODE_EXCEPTION_EN
        EXCEPTION: begin
          exc_flag = 1'b1;
          pc_src   = PCSRC_EXC;
          pc_write = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
